// File: rtl/nzp_branch_unit.sv
// Per-thread NZP flags plus 3-cycle BR resolution (accept -> EVAL -> RESOLVE/br_done); br_ready low while busy.
// Optional NZP_DIVERGE_EN: all-taken / none / divergent resolution; otherwise any-taken policy, divergent tied 0.
module nzp_branch_unit #(
  parameter int THREADS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [THREADS-1:0]               thread_mask,
  input  logic                             cmp_valid,
  input  logic [THREADS*DATA_WIDTH-1:0]    cmp_a,
  input  logic [THREADS*DATA_WIDTH-1:0]    cmp_b,
  input  logic                             br_valid,
  output logic                             br_ready,
  input  logic [2:0]                       br_nzp,
  input  logic [PC_WIDTH-1:0]              br_target,
  input  logic [PC_WIDTH-1:0]              pc_in,
  output logic [3*THREADS-1:0]             nzp_flags,
  output logic                             br_done,
  output logic [PC_WIDTH-1:0]              next_pc,
  output logic [THREADS-1:0]               taken_mask,
  output logic                             divergent
);

  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} state_t;

  state_t              state, state_nxt;
  logic                br_accept;
  logic [2:0]          nzp_cap;
  logic [PC_WIDTH-1:0] target_cap;
  logic [PC_WIDTH-1:0] pc_cap;
  logic [THREADS-1:0]  mask_cap;
  logic [THREADS-1:0]  taken_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                any_taken;

  for (genvar i = 0; i < THREADS; i++) begin : g_thr
    logic signed [DATA_WIDTH:0] a_ext, b_ext, diff;
    logic [2:0]                 cmp_nzp;
    logic [2:0]                 flags_q;

    // One extra bit keeps the signed difference exact (e.g. 127 - (-128)).
    assign a_ext   = {cmp_a[i*DATA_WIDTH+DATA_WIDTH-1], cmp_a[i*DATA_WIDTH +: DATA_WIDTH]};
    assign b_ext   = {cmp_b[i*DATA_WIDTH+DATA_WIDTH-1], cmp_b[i*DATA_WIDTH +: DATA_WIDTH]};
    assign diff    = a_ext - b_ext;
    assign cmp_nzp = diff[DATA_WIDTH] ? 3'b100 : (diff == '0) ? 3'b010 : 3'b001;

    always_ff @(posedge clk) begin
      if (reset) begin
        flags_q <= 3'b000;
      end else if (cmp_valid && thread_mask[i]) begin
        flags_q <= cmp_nzp;
      end
    end

    assign nzp_flags[3*i +: 3] = flags_q;
    assign taken_nxt[i]        = mask_cap[i] & (|(flags_q & nzp_cap));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    br_ready  = 1'b0;
    br_done   = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid) state_nxt = EVAL;
      end
      EVAL:    state_nxt = RESOLVE;
      RESOLVE: begin
        br_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign br_accept = br_valid & br_ready;
  assign any_taken = |taken_nxt;
  assign pc_inc    = pc_cap + PC_WIDTH'(1);

`ifdef NZP_DIVERGE_EN
  logic all_taken;
  logic div_nxt;
  logic div_q;

  // An empty captured mask is never "all taken", so it falls through to pc+1.
  assign all_taken = (mask_cap != '0) && (taken_nxt == mask_cap);
  assign div_nxt   = any_taken & ~all_taken;
  assign pc_nxt    = all_taken ? target_cap : pc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
    end else if (state == EVAL) begin
      div_q <= div_nxt;
    end
  end

  assign divergent = div_q;
`else
  assign pc_nxt    = any_taken ? target_cap : pc_inc;
  assign divergent = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      nzp_cap    <= 3'b000;
      target_cap <= '0;
      pc_cap     <= '0;
      mask_cap   <= '0;
      taken_mask <= '0;
      next_pc    <= '0;
    end else begin
      if (br_accept) begin
        nzp_cap    <= br_nzp;
        target_cap <= br_target;
        pc_cap     <= pc_in;
        mask_cap   <= thread_mask;
      end
      // Results settle at the end of EVAL so they are stable while br_done is high.
      if (state == EVAL) begin
        taken_mask <= taken_nxt;
        next_pc    <= pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_nzp_branch_unit.sv
module tb_nzp_branch_unit;
  localparam int T  = 4;
  localparam int DW = 8;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [T-1:0]      thread_mask;
  logic              cmp_valid;
  logic [T*DW-1:0]   cmp_a, cmp_b;
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_nzp;
  logic [PW-1:0]     br_target, pc_in;
  logic [3*T-1:0]    nzp_flags;
  logic              br_done;
  logic [PW-1:0]     next_pc;
  logic [T-1:0]      taken_mask;
  logic              divergent;

  always #5 clk = ~clk;

  nzp_branch_unit #(.THREADS(T), .DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .thread_mask(thread_mask), .cmp_valid(cmp_valid),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .br_valid(br_valid), .br_ready(br_ready),
    .br_nzp(br_nzp), .br_target(br_target), .pc_in(pc_in), .nzp_flags(nzp_flags),
    .br_done(br_done), .next_pc(next_pc), .taken_mask(taken_mask), .divergent(divergent)
  );

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [T-1:0]  tm;
    logic          dv;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       last = '0;
  logic [2:0] mflags [T];
  int         phase = 0;   // 0 idle, 1 evaluating, 2 result presented

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] ref_flags(logic [DW-1:0] a, logic [DW-1:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    if (d < 0)       return 3'b100;
    else if (d == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic exp_t ref_br(logic [2:0] nzp, logic [PW-1:0] tgt, logic [PW-1:0] pc,
                                  logic [T-1:0] mask);
    exp_t          e;
    int            n_act, n_tak;
    logic [PW-1:0] pc1;
    e     = '0;
    n_act = 0;
    n_tak = 0;
    for (int i = 0; i < T; i++) begin
      if (mask[i]) begin
        n_act++;
        if ((mflags[i] & nzp) != 3'b000) begin
          e.tm[i] = 1'b1;
          n_tak++;
        end
      end
    end
    pc1 = PW'((int'(pc) + 1) % (1 << PW));
`ifdef NZP_DIVERGE_EN
    e.pc = (n_act > 0 && n_tak == n_act) ? tgt : pc1;
    e.dv = (n_tak > 0 && n_tak < n_act);
`else
    e.pc = (n_tak > 0) ? tgt : pc1;
    e.dv = 1'b0;
`endif
    return e;
  endfunction

  // Reference model: follows the input protocol on each rising edge.
  always @(posedge clk) begin
    logic acc;
    if (reset) begin
      phase = 0;
      q.delete();
      for (int i = 0; i < T; i++) mflags[i] = 3'b000;
      last = '0;
    end else begin
      acc = br_valid && (phase == 0);
      if (cmp_valid)
        for (int i = 0; i < T; i++)
          if (thread_mask[i]) mflags[i] = ref_flags(cmp_a[i*DW +: DW], cmp_b[i*DW +: DW]);
      case (phase)
        0: if (acc) begin
             q.push_back(ref_br(br_nzp, br_target, pc_in, thread_mask));
             phase = 1;
           end
        1: phase = 2;
        default: phase = 0;
      endcase
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    logic [3*T-1:0] ef;
    for (int i = 0; i < T; i++) ef[3*i +: 3] = mflags[i];
    chk("nzp_flags", nzp_flags, ef);
    chk("br_ready", br_ready, phase == 0);
    chk("br_done", br_done, phase == 2);
    if (br_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        last = q.pop_front();
      end
    end
    chk("next_pc", next_pc, last.pc);
    chk("taken_mask", taken_mask, last.tm);
    chk("divergent", divergent, last.dv);
  end

  task automatic issue_br(logic [2:0] nzp, logic [PW-1:0] tgt, logic [PW-1:0] pc, logic [T-1:0] mask);
    int n = 0;
    br_valid = 1'b1; br_nzp = nzp; br_target = tgt; pc_in = pc; thread_mask = mask;
    while (br_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("br_ready_timeout", 0, 1);
    @(negedge clk);
    br_valid  = 1'b0;
    cmp_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (br_done !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6) chk("br_done_timeout", 0, 1);
  endtask

  initial begin
    int dones;
    reset = 1'b1; thread_mask = '0; cmp_valid = 1'b0; cmp_a = '0; cmp_b = '0;
    br_valid = 1'b0; br_nzp = 3'b000; br_target = '0; pc_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", nzp_flags, 0);
    chk("rst_ready", br_ready, 1);
    chk("rst_done", br_done, 0);
    chk("rst_next_pc", next_pc, 0);
    reset = 1'b0;
    @(negedge clk);

    // CMP: a={5,3,-2,127}, b={3,3,1,-128}
    cmp_valid = 1'b1; thread_mask = 4'b1111;
    cmp_a = {8'd127, 8'hFE, 8'd3, 8'd5};
    cmp_b = {8'h80,  8'd1,  8'd3, 8'd3};
    @(negedge clk);
    cmp_valid = 1'b0;
    chk("cmp_flags", nzp_flags, 12'b001_100_010_001);

    // Uniform branch
    issue_br(3'b011, 8'h40, 8'h10, 4'b1011);
    wait_done();
    chk("uni_taken", taken_mask, 4'b1011);
    chk("uni_pc", next_pc, 8'h40);
    chk("uni_div", divergent, 0);
    @(negedge clk);

    // Divergent branch with PC wrap
    issue_br(3'b001, 8'h20, 8'hFF, 4'b1111);
    wait_done();
    chk("div_taken", taken_mask, 4'b1001);
`ifdef NZP_DIVERGE_EN
    chk("div_pc", next_pc, 8'h00);
    chk("div_div", divergent, 1);
`else
    chk("div_pc", next_pc, 8'h20);
    chk("div_div", divergent, 0);
`endif
    @(negedge clk);

    // CMP in the same cycle as BR acceptance, then a BR request while busy
    cmp_valid = 1'b1; thread_mask = 4'b0001; cmp_a = '0; cmp_b = {24'd0, 8'd1};
    issue_br(3'b100, 8'h77, 8'h30, 4'b0001);
    br_valid = 1'b1; br_nzp = 3'b010; br_target = 8'h55; pc_in = 8'h60; thread_mask = 4'b1111;
    chk("busy_ready", br_ready, 0);
    @(negedge clk);
    br_valid = 1'b0;
    chk("sim_taken", taken_mask, 4'b0001);
    chk("sim_pc", next_pc, 8'h77);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (br_done === 1'b1) dones++;
    end
    chk("busy_ignored", dones, 0);

    // Reset during EVAL
    issue_br(3'b111, 8'h99, 8'h01, 4'b1111);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_done", br_done, 0);
    chk("midrst_ready", br_ready, 1);
    chk("midrst_flags", nzp_flags, 0);
    @(negedge clk);
    chk("midrst_done2", br_done, 0);

    // Fresh flags are 000, so nzp=111 is not taken
    issue_br(3'b111, 8'h12, 8'h34, 4'b1111);
    wait_done();
    chk("zero_flags_taken", taken_mask, 0);
    @(negedge clk);

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      cmp_valid   = $urandom_range(0, 2) == 0;
      thread_mask = T'($urandom);
      cmp_a       = (T*DW)'({$urandom, $urandom});
      cmp_b       = ($urandom_range(0, 3) == 0) ? cmp_a : (T*DW)'({$urandom, $urandom});
      br_valid    = $urandom_range(0, 1) == 1;
      br_nzp      = 3'($urandom);
      br_target   = PW'($urandom);
      pc_in       = ($urandom_range(0, 7) == 0) ? {PW{1'b1}} : PW'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; br_valid = 1'b0; cmp_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
